// File: rtl/frame_sequencer_pkg.sv
// Shared definitions for the frame sequencer: state encoding, pixel-source select
// and the screen/sprite geometry of the two ROM draw engines.
package frame_sequencer_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_BG_RUN = 3'd1;
  localparam logic [2:0] ST_BG_REL = 3'd2;
  localparam logic [2:0] ST_SP_RUN = 3'd3;
  localparam logic [2:0] ST_SP_REL = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_BG_RUN = ST_BG_RUN,
    S_BG_REL = ST_BG_REL,
    S_SP_RUN = ST_SP_RUN,
    S_SP_REL = ST_SP_REL
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BG   = 2'd1,
    SRC_SP   = 2'd2
  } pix_src_e;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int SPRITE_W = 40;
  localparam int SPRITE_H = 40;

  function automatic pix_src_e src_for_state(input state_e s);
    case (s)
      S_BG_RUN, S_BG_REL: return SRC_BG;
      S_SP_RUN, S_SP_REL: return SRC_SP;
      default:            return SRC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// Engine handshakes and the VGA write port seen by the frame sequencer.
// master = sequencer side, slave = engines plus VGA adapter side.
interface frame_sequencer_if #(
  parameter int X_WIDTH  = 8,
  parameter int Y_WIDTH  = 7,
  parameter int SP_WIDTH = 6
);

  logic                bgStart;
  logic [X_WIDTH-1:0]  bgX;
  logic [Y_WIDTH-1:0]  bgY;
  logic [7:0]          bgColour;
  logic                bgWriteEn;
  logic                bgDone;

  logic                spStart;
  logic [SP_WIDTH-1:0] spXInit;
  logic [SP_WIDTH-1:0] spYInit;
  logic [SP_WIDTH-1:0] spX;
  logic [SP_WIDTH-1:0] spY;
  logic [7:0]          spColour;
  logic                spWriteEn;
  logic                spDone;

  logic [X_WIDTH-1:0]  vgaX;
  logic [Y_WIDTH-1:0]  vgaY;
  logic [7:0]          vgaColour;
  logic                vgaWriteEn;

  modport master (
    output bgStart, spStart, spXInit, spYInit,
    output vgaX, vgaY, vgaColour, vgaWriteEn,
    input  bgX, bgY, bgColour, bgWriteEn, bgDone,
    input  spX, spY, spColour, spWriteEn, spDone
  );

  modport slave (
    input  bgStart, spStart, spXInit, spYInit,
    input  vgaX, vgaY, vgaColour, vgaWriteEn,
    output bgX, bgY, bgColour, bgWriteEn, bgDone,
    output spX, spY, spColour, spWriteEn, spDone
  );

endinterface

// File: rtl/frame_sequencer_pixel_mux_reg.sv
// Registered 2:1 pixel-stream mux. Only the selected engine's strobe is passed;
// with no source selected the strobe is low and the coordinates/colour hold.
module pixel_mux_reg
  import frame_sequencer_pkg::*;
#(
  parameter int X_WIDTH  = 8,
  parameter int Y_WIDTH  = 7,
  parameter int SP_WIDTH = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  pix_src_e            src,
  input  logic [X_WIDTH-1:0]  bg_x,
  input  logic [Y_WIDTH-1:0]  bg_y,
  input  logic [7:0]          bg_colour,
  input  logic                bg_write_en,
  input  logic [SP_WIDTH-1:0] sp_x,
  input  logic [SP_WIDTH-1:0] sp_y,
  input  logic [7:0]          sp_colour,
  input  logic                sp_write_en,
  output logic [X_WIDTH-1:0]  vga_x,
  output logic [Y_WIDTH-1:0]  vga_y,
  output logic [7:0]          vga_colour,
  output logic                vga_write_en
);

  logic [X_WIDTH-1:0] vga_x_q, vga_x_d;
  logic [Y_WIDTH-1:0] vga_y_q, vga_y_d;
  logic [7:0]         vga_colour_q, vga_colour_d;
  logic               vga_write_en_q, vga_write_en_d;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    vga_x_d        = vga_x_q;
    vga_y_d        = vga_y_q;
    vga_colour_d   = vga_colour_q;
    vga_write_en_d = 1'b0;
    case (src)
      SRC_BG: begin
        vga_x_d        = bg_x;
        vga_y_d        = bg_y;
        vga_colour_d   = bg_colour;
        vga_write_en_d = bg_write_en;
      end
      SRC_SP: begin
        // Sprite coordinates are narrower; the size cast zero-extends (or truncates) them.
        vga_x_d        = X_WIDTH'(sp_x);
        vga_y_d        = Y_WIDTH'(sp_y);
        vga_colour_d   = sp_colour;
        vga_write_en_d = sp_write_en;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      vga_x_q        <= '0;
      vga_y_q        <= '0;
      vga_colour_q   <= '0;
      vga_write_en_q <= 1'b0;
    end else begin
      vga_x_q        <= vga_x_d;
      vga_y_q        <= vga_y_d;
      vga_colour_q   <= vga_colour_d;
      vga_write_en_q <= vga_write_en_d;
    end
  end

  assign vga_x        = vga_x_q;
  assign vga_y        = vga_y_q;
  assign vga_colour   = vga_colour_q;
  assign vga_write_en = vga_write_en_q;

endmodule

// File: rtl/frame_sequencer.sv
// Frame sequencer: on each frame tick runs the background engine, then optionally
// the sprite engine, muxing their pixels onto the VGA port and counting dropped ticks.
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int X_WIDTH    = 8,
  parameter int Y_WIDTH    = 7,
  parameter int SP_WIDTH   = 6,
  parameter int MISS_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frameTick,
  input  logic                  spriteEn,
  input  logic [SP_WIDTH-1:0]   spriteX,
  input  logic [SP_WIDTH-1:0]   spriteY,
  frame_sequencer_if.master     bus,
  output logic                  busy,
  output logic                  frameDone,
  output logic [MISS_WIDTH-1:0] missed
);

  state_e                state_q, state_d;
  logic                  pending_q, pending_d;
  logic                  sp_en_q, sp_en_d;
  logic [SP_WIDTH-1:0]   sp_x_init_q, sp_x_init_d;
  logic [SP_WIDTH-1:0]   sp_y_init_q, sp_y_init_d;
  logic                  frame_done_q, frame_done_d;
  logic [MISS_WIDTH-1:0] missed_q, missed_d;

  logic engines_idle;

  // A fresh start is only legal once both engines have dropped done.
  assign engines_idle = !bus.bgDone && !bus.spDone;

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    sp_en_d      = sp_en_q;
    sp_x_init_d  = sp_x_init_q;
    sp_y_init_d  = sp_y_init_q;
    frame_done_d = 1'b0;
    missed_d     = missed_q;

    case (state_q)
      S_IDLE: begin
        if ((frameTick || pending_q) && engines_idle) begin
          sp_en_d     = spriteEn;
          sp_x_init_d = spriteX;
          sp_y_init_d = spriteY;
          pending_d   = 1'b0;
          state_d     = S_BG_RUN;
        end else if (frameTick) begin
          pending_d = 1'b1;
        end
      end
      S_BG_RUN: begin
        if (bus.bgDone) state_d = S_BG_REL;
      end
      S_BG_REL: begin
        if (!bus.bgDone) begin
          if (sp_en_q) begin
            state_d = S_SP_RUN;
          end else begin
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
          end
        end
      end
      S_SP_RUN: begin
        if (bus.spDone) state_d = S_SP_REL;
      end
      S_SP_REL: begin
        if (!bus.spDone) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Ticks outside IDLE are dropped, including the one landing on the return edge.
    if (frameTick && (state_q != S_IDLE) && (missed_q != '1)) begin
      missed_d = missed_q + MISS_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pending_q    <= 1'b0;
      sp_en_q      <= 1'b0;
      sp_x_init_q  <= '0;
      sp_y_init_q  <= '0;
      frame_done_q <= 1'b0;
      missed_q     <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      sp_en_q      <= sp_en_d;
      sp_x_init_q  <= sp_x_init_d;
      sp_y_init_q  <= sp_y_init_d;
      frame_done_q <= frame_done_d;
      missed_q     <= missed_d;
    end
  end

  // Starts decode straight from the state register, so a reset drops them on the same edge.
  assign bus.bgStart = (state_q == S_BG_RUN);
  assign bus.spStart = (state_q == S_SP_RUN);
  assign bus.spXInit = sp_x_init_q;
  assign bus.spYInit = sp_y_init_q;

  assign busy      = (state_q != S_IDLE);
  assign frameDone = frame_done_q;
  assign missed    = missed_q;

  pixel_mux_reg #(
    .X_WIDTH  (X_WIDTH),
    .Y_WIDTH  (Y_WIDTH),
    .SP_WIDTH (SP_WIDTH)
  ) u_pixel_mux_reg (
    .clk          (clk),
    .reset        (reset),
    .src          (src_for_state(state_q)),
    .bg_x         (bus.bgX),
    .bg_y         (bus.bgY),
    .bg_colour    (bus.bgColour),
    .bg_write_en  (bus.bgWriteEn),
    .sp_x         (bus.spX),
    .sp_y         (bus.spY),
    .sp_colour    (bus.spColour),
    .sp_write_en  (bus.spWriteEn),
    .vga_x        (bus.vgaX),
    .vga_y        (bus.vgaY),
    .vga_colour   (bus.vgaColour),
    .vga_write_en (bus.vgaWriteEn)
  );

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: small bg (4x2) and sprite (2x2) engine models, an
// expected-pixel queue checked every cycle, and directed scenario checks.
module tb_frame_sequencer;

  localparam int XW  = 8;
  localparam int YW  = 7;
  localparam int SPW = 6;
  localparam int MW  = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           frameTick = 1'b0;
  logic           spriteEn = 1'b0;
  logic [SPW-1:0] spriteX = '0;
  logic [SPW-1:0] spriteY = '0;
  logic           busy;
  logic           frameDone;
  logic [MW-1:0]  missed;

  frame_sequencer_if #(.X_WIDTH(XW), .Y_WIDTH(YW), .SP_WIDTH(SPW)) bus ();

  frame_sequencer #(.X_WIDTH(XW), .Y_WIDTH(YW), .SP_WIDTH(SPW), .MISS_WIDTH(MW)) dut (
    .clk       (clk),
    .reset     (reset),
    .frameTick (frameTick),
    .spriteEn  (spriteEn),
    .spriteX   (spriteX),
    .spriteY   (spriteY),
    .bus       (bus),
    .busy      (busy),
    .frameDone (frameDone),
    .missed    (missed)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int          stamp;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [7:0]  c;
    bit          is_sp;
  } pix_t;

  pix_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Engine model state and knobs
  int bg_phase, bg_cnt, bg_wait, bg_rel, bg_delay;
  int sp_phase, sp_cnt, sp_rel;
  bit bg_done_m, sp_done_m, bg_done_force, stray_bg, stray_sp;
  int bg_fall_cyc = -10;
  int m_sx, m_sy;

  // Observation tallies
  bit chk_en = 1'b0;
  bit lat_chk = 1'b0;
  bit bg_start_prev = 1'b0;
  int bg_launches = 0, sp_start_cycles = 0, fd_count = 0, fd_cyc = -10;
  int bg_seen = 0, sp_seen = 0;
  int sp_xmin, sp_xmax, sp_ymin, sp_ymax;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic engine_reset();
    bg_phase = 0; bg_cnt = 0; bg_wait = 0; bg_rel = 0; bg_done_m = 1'b0;
    sp_phase = 0; sp_cnt = 0; sp_rel = 0; sp_done_m = 1'b0;
    bus.bgWriteEn = 1'b0; bus.spWriteEn = 1'b0;
    bus.bgDone = bg_done_force; bus.spDone = 1'b0;
  endtask

  task automatic engine_step();
    bus.bgWriteEn = 1'b0;
    case (bg_phase)
      0: if (bus.bgStart && !bus.bgDone) begin bg_phase = 1; bg_cnt = 0; bg_wait = bg_delay; end
      1: begin
        if (!bus.bgStart) bg_phase = 0;
        else if (bg_wait > 0) bg_wait--;
        else begin
          bus.bgWriteEn = 1'b1;
          bus.bgX = XW'(bg_cnt % 4);
          bus.bgY = YW'(bg_cnt / 4);
          bus.bgColour = 8'(16 + bg_cnt);
          exp_q.push_back('{stamp: cyc, x: XW'(bg_cnt % 4), y: YW'(bg_cnt / 4),
                            c: 8'(16 + bg_cnt), is_sp: 1'b0});
          bg_cnt++;
          if (bg_cnt == 8) bg_phase = 2;
        end
      end
      2: begin
        bg_done_m = 1'b1;
        if (!bus.bgStart) begin bg_phase = 3; bg_rel = 2; end
      end
      default: begin
        bg_rel--;
        if (bg_rel == 0) begin bg_done_m = 1'b0; bg_phase = 0; bg_fall_cyc = cyc; end
      end
    endcase
    if (stray_bg) begin
      bus.bgWriteEn = 1'b1; bus.bgX = 8'hAA; bus.bgY = 7'h55; bus.bgColour = 8'hCC;
    end
    bus.bgDone = bg_done_m | bg_done_force;

    bus.spWriteEn = 1'b0;
    case (sp_phase)
      0: if (bus.spStart && !bus.spDone) begin sp_phase = 1; sp_cnt = 0; end
      1: begin
        if (!bus.spStart) sp_phase = 0;
        else begin
          // The engine adds its own offset to the origin it was handed.
          bus.spWriteEn = 1'b1;
          bus.spX = bus.spXInit + SPW'(sp_cnt % 2);
          bus.spY = bus.spYInit + SPW'(sp_cnt / 2);
          bus.spColour = 8'(128 + sp_cnt);
          exp_q.push_back('{stamp: cyc, x: XW'(m_sx + sp_cnt % 2), y: YW'(m_sy + sp_cnt / 2),
                            c: 8'(128 + sp_cnt), is_sp: 1'b1});
          sp_cnt++;
          if (sp_cnt == 4) sp_phase = 2;
        end
      end
      2: begin
        sp_done_m = 1'b1;
        if (!bus.spStart) begin sp_phase = 3; sp_rel = 2; end
      end
      default: begin
        sp_rel--;
        if (sp_rel == 0) begin sp_done_m = 1'b0; sp_phase = 0; end
      end
    endcase
    if (stray_sp) begin
      bus.spWriteEn = 1'b1; bus.spX = '1; bus.spY = '1; bus.spColour = 8'hEE;
    end
    bus.spDone = sp_done_m;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    engine_step();
  end

  // Per-cycle compare against the expected pixel stream (1-cycle latency).
  initial forever begin
    @(negedge clk);
    if (bus.bgStart && !bg_start_prev) bg_launches++;
    bg_start_prev = bus.bgStart;
    if (bus.spStart) sp_start_cycles++;
    if (frameDone) begin fd_count++; fd_cyc = cyc; end
    if (chk_en) begin
      if (bus.bgStart || bus.spStart) check("start_overlap", 32'(bus.bgStart & bus.spStart), 0);
      if (lat_chk && busy) check("spXInit_latched", 32'(bus.spXInit), m_sx);
      while (exp_q.size() > 0 && exp_q[0].stamp < cyc - 1) begin
        check("pixel_latency", cyc - 1, exp_q[0].stamp);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].stamp == cyc - 1) begin
        check("pix_wen", 32'(bus.vgaWriteEn), 1);
        check("pix_x", 32'(bus.vgaX), 32'(exp_q[0].x));
        check("pix_y", 32'(bus.vgaY), 32'(exp_q[0].y));
        check("pix_colour", 32'(bus.vgaColour), 32'(exp_q[0].c));
        if (exp_q[0].is_sp) begin
          sp_seen++;
          if (int'(bus.vgaX) < sp_xmin) sp_xmin = int'(bus.vgaX);
          if (int'(bus.vgaX) > sp_xmax) sp_xmax = int'(bus.vgaX);
          if (int'(bus.vgaY) < sp_ymin) sp_ymin = int'(bus.vgaY);
          if (int'(bus.vgaY) > sp_ymax) sp_ymax = int'(bus.vgaY);
        end else begin
          bg_seen++;
        end
        void'(exp_q.pop_front());
      end else begin
        check("unexpected_wen", 32'(bus.vgaWriteEn), 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic pulse_tick();
    frameTick = 1'b1;
    next();
    frameTick = 1'b0;
  endtask

  task automatic wait_fd(input int fd0, input int budget);
    int n = 0;
    while (fd_count == fd0 && n < budget) begin next(); n++; end
    check("frame_done_within_budget", 32'(fd_count > fd0), 1);
  endtask

  task automatic launch(input bit en, input int sx, input int sy);
    spriteEn = en; spriteX = SPW'(sx); spriteY = SPW'(sy);
    m_sx = sx; m_sy = sy;
    sp_xmin = 999; sp_xmax = -1; sp_ymin = 999; sp_ymax = -1;
  endtask

  initial begin
    int fd0, bg0, sp0, spc0, bl0, n;
    bg_delay = 0; bg_done_force = 1'b0; stray_bg = 1'b0; stray_sp = 1'b0;
    engine_reset();
    bus.bgX = '0; bus.bgY = '0; bus.bgColour = '0;
    bus.spX = '0; bus.spY = '0; bus.spColour = '0;
    repeat (3) next();

    // Reset state
    check("rst_busy", 32'(busy), 0);
    check("rst_bgStart", 32'(bus.bgStart), 0);
    check("rst_spStart", 32'(bus.spStart), 0);
    check("rst_vgaWriteEn", 32'(bus.vgaWriteEn), 0);
    check("rst_vgaX", 32'(bus.vgaX), 0);
    check("rst_frameDone", 32'(frameDone), 0);
    check("rst_missed", 32'(missed), 0);
    check("rst_spXInit", 32'(bus.spXInit), 0);
    reset = 1'b0;
    chk_en = 1'b1;
    next();

    // Full frame with sprite at (5,3)
    launch(1'b1, 5, 3);
    fd0 = fd_count; bg0 = bg_seen; sp0 = sp_seen;
    pulse_tick();
    wait_fd(fd0, 200);
    repeat (4) next();
    check("full_bg_writes", bg_seen - bg0, 8);
    check("full_sp_writes", sp_seen - sp0, 4);
    check("full_frame_done_once", fd_count - fd0, 1);
    check("full_sp_xmin", sp_xmin, 5);
    check("full_sp_xmax", sp_xmax, 6);
    check("full_sp_ymin", sp_ymin, 3);
    check("full_sp_ymax", sp_ymax, 4);
    check("full_queue_drained", exp_q.size(), 0);
    check("full_busy_after", 32'(busy), 0);

    // Sprite skipped; stray sprite strobes; tick on the return-to-IDLE edge
    launch(1'b0, 7, 7);
    fd0 = fd_count; bg0 = bg_seen; sp0 = sp_seen; spc0 = sp_start_cycles; bl0 = bg_launches;
    stray_sp = 1'b1;
    pulse_tick();
    n = 0;
    while (bg_fall_cyc != cyc && n < 200) begin next(); n++; end
    check("skip_bg_done_fell", 32'(bg_fall_cyc == cyc), 1);
    pulse_tick();
    stray_sp = 1'b0;
    wait_fd(fd0, 50);
    check("skip_fd_after_bgdone_fall", fd_cyc - bg_fall_cyc, 1);
    repeat (4) next();
    check("skip_bg_writes", bg_seen - bg0, 8);
    check("skip_sp_writes", sp_seen - sp0, 0);
    check("skip_spStart_never", sp_start_cycles - spc0, 0);
    check("skip_frame_done_once", fd_count - fd0, 1);
    check("skip_edge_tick_missed", 32'(missed), 1);
    check("skip_no_relaunch", bg_launches - bl0, 1);
    check("skip_idle_after", 32'(busy), 0);

    // Stray bg strobes in IDLE; VGA fields hold the last bg pixel
    stray_bg = 1'b1;
    repeat (3) next();
    stray_bg = 1'b0;
    next();
    check("hold_vgaX", 32'(bus.vgaX), 3);
    check("hold_vgaY", 32'(bus.vgaY), 1);
    check("hold_vgaColour", 32'(bus.vgaColour), 32'h17);

    // Stale done: tick is held off while bgDone is high
    launch(1'b0, 0, 0);
    fd0 = fd_count;
    bg_done_force = 1'b1;
    bus.bgDone = 1'b1;
    next();
    pulse_tick();
    for (int i = 0; i < 4; i++) begin
      check("stale_bgStart_low", 32'(bus.bgStart), 0);
      next();
    end
    check("stale_busy_low", 32'(busy), 0);
    bg_done_force = 1'b0;
    bus.bgDone = bg_done_m;
    next();
    check("stale_bgStart_1cycle", 32'(bus.bgStart), 1);
    check("stale_busy_1cycle", 32'(busy), 1);
    wait_fd(fd0, 200);
    repeat (4) next();
    check("stale_missed_unchanged", 32'(missed), 1);

    // Latched sprite origin survives input changes mid-frame
    launch(1'b1, 5, 3);
    fd0 = fd_count; sp0 = sp_seen;
    lat_chk = 1'b1;
    pulse_tick();
    spriteX = SPW'(30); spriteY = SPW'(20); spriteEn = 1'b0;
    wait_fd(fd0, 200);
    lat_chk = 1'b0;
    repeat (4) next();
    check("latch_sp_writes", sp_seen - sp0, 4);
    check("latch_spXInit_after", 32'(bus.spXInit), 5);

    // 20 ticks while drawing: missed saturates, no relaunch, one frameDone
    launch(1'b0, 0, 0);
    bg_delay = 30;
    fd0 = fd_count; bl0 = bg_launches; bg0 = bg_seen;
    pulse_tick();
    frameTick = 1'b1;
    repeat (20) next();
    frameTick = 1'b0;
    check("drop_missed_saturated", 32'(missed), 15);
    check("drop_still_busy", 32'(busy), 1);
    wait_fd(fd0, 200);
    bg_delay = 0;
    repeat (6) next();
    check("drop_single_launch", bg_launches - bl0, 1);
    check("drop_frame_done_once", fd_count - fd0, 1);
    check("drop_bg_writes", bg_seen - bg0, 8);
    check("drop_idle_after", 32'(busy), 0);

    // Reset asserted during SP_RUN
    launch(1'b1, 5, 3);
    pulse_tick();
    n = 0;
    while (!bus.spStart && n < 200) begin next(); n++; end
    check("rst_reached_sp_run", 32'(bus.spStart), 1);
    next();
    chk_en = 1'b0;
    reset = 1'b1;
    next();
    check("midrst_spStart", 32'(bus.spStart), 0);
    check("midrst_bgStart", 32'(bus.bgStart), 0);
    check("midrst_vgaWriteEn", 32'(bus.vgaWriteEn), 0);
    check("midrst_missed", 32'(missed), 0);
    check("midrst_busy", 32'(busy), 0);
    reset = 1'b0;
    engine_reset();
    exp_q.delete();
    next();
    next();
    chk_en = 1'b1;

    // Recovery frame after reset
    launch(1'b0, 0, 0);
    fd0 = fd_count; bg0 = bg_seen;
    pulse_tick();
    wait_fd(fd0, 200);
    repeat (4) next();
    check("recover_bg_writes", bg_seen - bg0, 8);
    check("recover_missed", 32'(missed), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
